// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done operand and result bundle for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract, one operand bit per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             bit_s;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  assign bit_s    = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_d  = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign res_d    = {bit_s, {(WIDTH-1){1'b0}}} | (res_q >> 1);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1, so the carry flop supplies the +1.
            opa_q   <= bus.a;
            opb_q   <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // carry_q is the carry into the MSB at this edge.
            sum_q   <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and exhaustive checks of serial_adder at WIDTH 8 and 3
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8();
  serial_adder_if #(.WIDTH(3)) if3();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the accepting edge; pulse_k re-asserts start with zero operands.
  task automatic run8(input logic s, input logic c, input logic [7:0] av, input logic [7:0] bv,
                      input int pulse_k, input logic [7:0] hold_exp,
                      output int lat, output int busy_n, output int done_n, output int hold_bad);
    if8.sub = s; if8.cin = c; if8.a = av; if8.b = bv; if8.start = 1'b1;
    tick;
    if8.start = 1'b0;
    lat = -1; busy_n = 0; done_n = 0; hold_bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == pulse_k) begin
        if8.start = 1'b1; if8.a = 8'h00; if8.b = 8'h00;
      end else begin
        if8.start = 1'b0;
      end
      if (if8.busy === 1'b1) busy_n++;
      if (if8.done === 1'b1) begin
        done_n++;
        if (lat < 0) lat = k;
      end
      if (k < 8 && if8.sum !== hold_exp) hold_bad++;
      tick;
    end
  endtask

  task automatic run3(input logic s, input logic c, input logic [2:0] av, input logic [2:0] bv,
                      output int lat);
    if3.sub = s; if3.cin = c; if3.a = av; if3.b = bv; if3.start = 1'b1;
    tick;
    if3.start = 1'b0;
    lat = -1;
    for (int k = 0; k < 5; k++) begin
      if (if3.done === 1'b1 && lat < 0) lat = k;
      tick;
    end
  endtask

  task automatic expect8(input string tag, input int lat, input int busy_n, input int done_n,
                         input int hold_bad, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_sum_held"}, hold_bad, 0);
    check({tag, "_sum"}, if8.sum, es);
    check({tag, "_cout"}, if8.cout, ec);
    check({tag, "_overflow"}, if8.overflow, eo);
  endtask

  initial begin
    int lat, busy_n, done_n, hold_bad;
    int ua, ub, r, sa, sb, sr;
    logic [2:0] es3;
    logic ec3, eo3;

    if8.start = 1'b0; if8.sub = 1'b0; if8.cin = 1'b0; if8.a = '0; if8.b = '0;
    if3.start = 1'b0; if3.sub = 1'b0; if3.cin = 1'b0; if3.a = '0; if3.b = '0;
    #12;
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    check("rst_sum", if8.sum, 0);
    check("rst_cout", if8.cout, 0);
    check("rst_overflow", if8.overflow, 0);
    check("rst_sum3", if3.sum, 0);
    rst_n = 1'b1;
    tick;

    run8(1'b0, 1'b0, 8'h3C, 8'h55, -1, 8'h00, lat, busy_n, done_n, hold_bad);
    expect8("add_3c_55", lat, busy_n, done_n, hold_bad, 8'h91, 1'b0, 1'b1);

    run8(1'b0, 1'b1, 8'hFF, 8'h01, -1, 8'h91, lat, busy_n, done_n, hold_bad);
    expect8("add_ff_01_cin", lat, busy_n, done_n, hold_bad, 8'h01, 1'b1, 1'b0);

    run8(1'b1, 1'b1, 8'h10, 8'h20, -1, 8'h01, lat, busy_n, done_n, hold_bad);
    expect8("sub_10_20", lat, busy_n, done_n, hold_bad, 8'hF0, 1'b0, 1'b0);

    run8(1'b1, 1'b0, 8'h80, 8'h01, -1, 8'hF0, lat, busy_n, done_n, hold_bad);
    expect8("sub_80_01", lat, busy_n, done_n, hold_bad, 8'h7F, 1'b1, 1'b1);

    run8(1'b0, 1'b0, 8'hC0, 8'hA0, 2, 8'h7F, lat, busy_n, done_n, hold_bad);
    expect8("ignored_start", lat, busy_n, done_n, hold_bad, 8'h60, 1'b1, 1'b1);

    if8.sub = 1'b0; if8.cin = 1'b0; if8.a = 8'h7A; if8.b = 8'h11; if8.start = 1'b1;
    tick;
    if8.start = 1'b0;
    tick; tick; tick;
    check("midrun_busy", if8.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", if8.busy, 0);
    check("abort_done", if8.done, 0);
    check("abort_sum", if8.sum, 0);
    check("abort_cout", if8.cout, 0);
    check("abort_overflow", if8.overflow, 0);
    #1 rst_n = 1'b1;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (if8.busy !== 1'b0) busy_n++;
      if (if8.done !== 1'b0) done_n++;
    end
    check("abort_no_busy", busy_n, 0);
    check("abort_no_done", done_n, 0);

    run8(1'b1, 1'b0, 8'h05, 8'h07, -1, 8'h00, lat, busy_n, done_n, hold_bad);
    expect8("post_abort_sub", lat, busy_n, done_n, hold_bad, 8'hFE, 1'b0, 1'b0);

    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int av = 0; av < 8; av++) begin
          for (int bv = 0; bv < 8; bv++) begin
            ua = av; ub = bv;
            sa = (av > 3) ? av - 8 : av;
            sb = (bv > 3) ? bv - 8 : bv;
            if (s == 0) begin
              r = ua + ub + c;
              ec3 = (r > 7);
              sr = sa + sb + c;
            end else begin
              r = ua - ub + 8;
              ec3 = (ua >= ub);
              sr = sa - sb;
            end
            es3 = 3'(r);
            eo3 = (sr > 3) || (sr < -4);
            run3(s[0], c[0], 3'(av), 3'(bv), lat);
            check($sformatf("w3_s%0d_c%0d_a%0d_b%0d_sum", s, c, av, bv), if3.sum, es3);
            check($sformatf("w3_s%0d_c%0d_a%0d_b%0d_cout", s, c, av, bv), if3.cout, ec3);
            check($sformatf("w3_s%0d_c%0d_a%0d_b%0d_ovf", s, c, av, bv), if3.overflow, eo3);
            check($sformatf("w3_s%0d_c%0d_a%0d_b%0d_lat", s, c, av, bv), lat, 3);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
